// File: rtl/uart_tx_dev.sv
// uart_tx_dev -- memory-mapped 8N1 UART transmitter with a small TX FIFO.
//
// Ports:
//   clk   in   1   system clock
//   rst   in   1   asynchronous, active-high reset
//   addr  in   2   register word select (0 TXDATA, 1 STATUS, 2 CTRL, 3 DIVISOR)
//   we    in   1   register write strobe, sampled at rising clk
//   din   in  32   write data
//   dout  out 32   read data, combinational from addr
//   irq   out  1   level interrupt: IE && FIFO empty && shifter idle, registered
//   txd   out  1   serial output, idle high
//
// Each serial bit lasts DIVISOR+1 clocks; a frame is start + 8 data (LSB first)
// + stop. The bit counter reloads from DIVISOR at every bit boundary, so a
// DIVISOR write mid-frame only affects bits that begin after it.
module uart_tx_dev #(
    parameter logic [15:0] RESET_DIV  = 16'd433,
    parameter int          FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [1:0]  addr,
    input  logic        we,
    input  logic [31:0] din,
    output logic [31:0] dout,
    output logic        irq,
    output logic        txd
);

    localparam int         PTR_W   = $clog2(FIFO_DEPTH);
    localparam logic [2:0] DEPTH_C = 3'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t             state, state_n;
    logic [7:0]         mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic [2:0]         count;
    logic               en, ie, ovf;
    logic [15:0]        divisor;
    logic [15:0]        cnt, cnt_n;
    logic [2:0]         idx, idx_n;
    logic [7:0]         shift;
    logic               empty, full, busy;
    logic               wr_data, push, pop;
    logic               unused_din;

    assign unused_din = ^din[31:16];

    assign empty   = (count == 3'd0);
    assign full    = (count == DEPTH_C);
    assign busy    = (state != IDLE);
    // FULL is the pre-pop value: a push against a full FIFO is dropped even
    // if the shifter pops in the same cycle.
    assign wr_data = we && (addr == 2'd0);
    assign push    = wr_data && !full;

    // ---- register file ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            en      <= 1'b0;
            ie      <= 1'b0;
            ovf     <= 1'b0;
            divisor <= RESET_DIV;
        end else if (we) begin
            case (addr)
                2'd0: if (full) ovf <= 1'b1;
                2'd1: ovf <= 1'b0;
                2'd2: {ie, en} <= din[1:0];
                default: divisor <= din[15:0];
            endcase
        end
    end

    always_comb begin
        dout = 32'd0;
        case (addr)
            2'd1: dout = {25'd0, ovf, count, busy, full, empty};
            2'd2: dout = {30'd0, ie, en};
            2'd3: dout = {16'd0, divisor};
            default: dout = 32'd0;
        endcase
    end

    // ---- TX FIFO ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + {2'd0, push} - {2'd0, pop};
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din[7:0];
    end

    // ---- shifter FSM ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        idx_n   = idx;
        pop     = 1'b0;
        case (state)
            IDLE: begin
                // empty is the registered count, so a byte pushed this edge
                // is popped no earlier than the next one.
                if (en && !empty) begin
                    pop     = 1'b1;
                    cnt_n   = divisor;
                    state_n = START;
                end
            end
            START: begin
                if (cnt == 16'd0) begin
                    cnt_n   = divisor;
                    idx_n   = 3'd0;
                    state_n = DATA;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            DATA: begin
                if (cnt == 16'd0) begin
                    cnt_n = divisor;
                    if (idx == 3'd7) state_n = STOP;
                    else             idx_n   = idx + 3'd1;
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            STOP: begin
                if (cnt == 16'd0) begin
                    // Chain straight into the next start bit when possible.
                    if (en && !empty) begin
                        pop     = 1'b1;
                        cnt_n   = divisor;
                        state_n = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    cnt_n = cnt - 16'd1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Datapath registers need no reset: IDLE reloads them before use.
    always_ff @(posedge clk) begin
        cnt <= cnt_n;
        idx <= idx_n;
        if (pop) shift <= mem[rd_ptr];
    end

    // txd decodes the async-reset state register, so reset forces it high at once.
    always_comb begin
        case (state)
            START:   txd = 1'b0;
            DATA:    txd = shift[idx];
            default: txd = 1'b1;
        endcase
    end

    // ---- interrupt ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) irq <= 1'b0;
        else     irq <= ie && empty && !busy;
    end

endmodule

// File: tb/tb_uart_tx_dev.sv
// tb_uart_tx_dev -- bench for uart_tx_dev: directed scenarios plus a random
// register-traffic phase, all compared every cycle against a queue-based
// frame model (byte FIFO + list of remaining bit levels).
module tb_uart_tx_dev;

    logic        clk;
    logic        rst;
    logic [1:0]  addr;
    logic        we;
    logic [31:0] din;
    logic [31:0] dout;
    logic        irq;
    logic        txd;

    int vecs = 0;
    int errs = 0;

    uart_tx_dev dut (
        .clk  (clk),
        .rst  (rst),
        .addr (addr),
        .we   (we),
        .din  (din),
        .dout (dout),
        .irq  (irq),
        .txd  (txd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---- reference model state ----
    logic [7:0]  fifo_q[$];
    bit          lvl_q[$];
    bit          active;
    bit          cur_lvl;
    int          cur_left;
    bit          m_en, m_ie, m_ovf, m_irq;
    logic [15:0] m_div;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s at %0t: got %h, expected %h", tag, $time, act, exp);
        end
    endtask

    task automatic model_reset();
        fifo_q.delete();
        lvl_q.delete();
        active   = 1'b0;
        cur_lvl  = 1'b1;
        cur_left = 0;
        m_en     = 1'b0;
        m_ie     = 1'b0;
        m_ovf    = 1'b0;
        m_irq    = 1'b0;
        m_div    = 16'd433;
    endtask

    // One rising edge of the model; all decisions use pre-edge values.
    task automatic model_edge(input logic w, input logic [1:0] a, input logic [31:0] d);
        bit          full_pre  = (fifo_q.size() == 4);
        bit          empty_pre = (fifo_q.size() == 0);
        bit          en_pre    = m_en;
        logic [15:0] div_pre   = m_div;
        bit          start     = 1'b0;
        logic [7:0]  b;
        m_irq = m_ie && empty_pre && !active;
        if (active) begin
            if (cur_left == 0) begin
                if (lvl_q.size() > 0) begin
                    cur_lvl  = lvl_q.pop_front();
                    cur_left = int'(div_pre);
                end else begin
                    active = 1'b0;
                    start  = en_pre && !empty_pre;
                end
            end else begin
                cur_left--;
            end
        end else begin
            start = en_pre && !empty_pre;
        end
        if (start) begin
            b        = fifo_q.pop_front();
            active   = 1'b1;
            cur_lvl  = 1'b0;
            cur_left = int'(div_pre);
            lvl_q.delete();
            for (int i = 0; i < 8; i++) lvl_q.push_back(b[i]);
            lvl_q.push_back(1'b1);
        end
        if (w) begin
            case (a)
                2'd0: if (full_pre) m_ovf = 1'b1; else fifo_q.push_back(d[7:0]);
                2'd1: m_ovf = 1'b0;
                2'd2: {m_ie, m_en} = d[1:0];
                default: m_div = d[15:0];
            endcase
        end
    endtask

    function automatic logic [31:0] exp_rd(input logic [1:0] a);
        logic [2:0] c = 3'(fifo_q.size());
        case (a)
            2'd1: return {25'd0, m_ovf, c, active, (c == 3'd4), (c == 3'd0)};
            2'd2: return {30'd0, m_ie, m_en};
            2'd3: return {16'd0, m_div};
            default: return 32'd0;
        endcase
    endfunction

    // Drive one cycle from a falling edge, step the model at the rising edge,
    // and compare at the next falling edge.
    task automatic cyc(input logic w, input logic [1:0] a, input logic [31:0] d);
        we   = w;
        addr = a;
        din  = d;
        @(posedge clk);
        model_edge(w, a, d);
        @(negedge clk);
        chk("txd",  {31'd0, txd}, {31'd0, (active ? cur_lvl : 1'b1)});
        chk("irq",  {31'd0, irq}, {31'd0, m_irq});
        chk("dout", dout, exp_rd(a));
        we = 1'b0;
    endtask

    initial begin
        int r;
        rst  = 1'b1;
        we   = 1'b0;
        addr = 2'd0;
        din  = 32'd0;
        model_reset();
        repeat (2) @(negedge clk);

        // Reset values
        chk("rst_txd", {31'd0, txd}, 32'd1);
        chk("rst_irq", {31'd0, irq}, 32'd0);
        addr = 2'd1; #1 chk("rst_status", dout, 32'h1);
        addr = 2'd2; #1 chk("rst_ctrl",   dout, 32'h0);
        addr = 2'd3; #1 chk("rst_div",    dout, 32'h1B1);
        @(negedge clk);
        rst = 1'b0;

        // Single 0x55 frame at DIVISOR=3
        cyc(1'b1, 2'd3, 32'd3);
        cyc(1'b1, 2'd2, 32'd1);
        cyc(1'b1, 2'd0, 32'h55);
        chk("start_lat_pre", {31'd0, txd}, 32'd1);
        cyc(1'b0, 2'd1, 32'd0);
        chk("start_lat", {31'd0, txd}, 32'd0);
        repeat (44) cyc(1'b0, 2'd1, 32'd0);

        // Fill with EN=0, overflow, then drain back-to-back at DIVISOR=0
        cyc(1'b1, 2'd2, 32'd0);
        cyc(1'b1, 2'd3, 32'd0);
        for (int i = 1; i <= 4; i++) cyc(1'b1, 2'd0, 32'(i));
        cyc(1'b0, 2'd1, 32'd0);
        chk("st_full", dout, 32'h22);
        cyc(1'b1, 2'd0, 32'd5);
        cyc(1'b0, 2'd1, 32'd0);
        chk("st_ovf", dout, 32'h62);
        cyc(1'b1, 2'd2, 32'd1);
        repeat (45) cyc(1'b0, 2'd1, 32'd0);
        cyc(1'b1, 2'd1, 32'd0);
        cyc(1'b0, 2'd1, 32'd0);
        chk("st_clr", dout, 32'h1);

        // Interrupt around a frame at DIVISOR=1
        cyc(1'b1, 2'd3, 32'd1);
        cyc(1'b1, 2'd2, 32'd3);
        cyc(1'b1, 2'd0, 32'hA5);
        repeat (25) cyc(1'b0, 2'd2, 32'd0);
        chk("irq_done", {31'd0, irq}, 32'd1);
        cyc(1'b1, 2'd0, 32'h3C);
        cyc(1'b0, 2'd1, 32'd0);
        chk("irq_drop", {31'd0, irq}, 32'd0);
        repeat (25) cyc(1'b0, 2'd1, 32'd0);

        // Asynchronous reset in the middle of a data bit
        cyc(1'b1, 2'd2, 32'd1);
        cyc(1'b1, 2'd3, 32'd3);
        cyc(1'b1, 2'd0, 32'hF0);
        repeat (8) cyc(1'b0, 2'd1, 32'd0);
        chk("pre_rst_txd", {31'd0, txd}, 32'd0);
        #2 rst = 1'b1;
        #1;
        chk("arst_txd",    {31'd0, txd}, 32'd1);
        chk("arst_status", dout, 32'h1);
        chk("arst_irq",    {31'd0, irq}, 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        repeat (30) cyc(1'b0, 2'd1, 32'd0);

        // DIVISOR change in mid-frame
        cyc(1'b1, 2'd3, 32'd3);
        cyc(1'b1, 2'd2, 32'd1);
        cyc(1'b1, 2'd0, 32'h96);
        repeat (6) cyc(1'b0, 2'd1, 32'd0);
        cyc(1'b1, 2'd3, 32'd7);
        repeat (90) cyc(1'b0, 2'd1, 32'd0);

        // Random register traffic with short bit periods
        cyc(1'b1, 2'd3, 32'd1);
        for (int n = 0; n < 1500; n++) begin
            r = int'($urandom_range(0, 99));
            if (r < 14)      cyc(1'b1, 2'd0, 32'($urandom_range(0, 255)));
            else if (r < 18) cyc(1'b1, 2'd2, 32'($urandom_range(0, 3)));
            else if (r < 21) cyc(1'b1, 2'd1, 32'd0);
            else if (r < 24) cyc(1'b1, 2'd3, 32'($urandom_range(0, 3)));
            else             cyc(1'b0, 2'($urandom_range(0, 3)), 32'd0);
        end
        cyc(1'b1, 2'd2, 32'd3);
        repeat (200) cyc(1'b0, 2'd1, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
